// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one external combinational ALU between NREQ requesters using a
//   round-robin arbiter. A granted request is captured into an issue
//   register (S) that drives the ALU inputs. The ALU result is captured into
//   a response register (R) that feeds a single tagged response channel.
//   The two stages sustain one operation per cycle under backpressure.
//
// Parameters:
//   NREQ           number of requesters (2..8)
//   ALU_CTRL_WIDTH width of the ALU control code (matches riscv_defines.svh)
//   IDW            requester ID width, $clog2(NREQ)
//
// Ports:
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   req_valid    in   [NREQ]        per-requester request valid
//   req_ready    out  [NREQ]        per-requester accept (one-hot or zero)
//   req_a        in   [NREQ*32]     operand A, requester i at [32*i+:32]
//   req_b        in   [NREQ*32]     operand B, same packing
//   req_ctrl     in   [NREQ*CW]     ALU control code per requester
//   req_lock     in   [NREQ]        keep the grant after this op
//   alu_a        out  [32]          ALU operand A (from S)
//   alu_b        out  [32]          ALU operand B (from S)
//   alu_ctrl     out  [CW]          ALU control (from S)
//   alu_result   in   [32]          ALU result
//   alu_zero     in                 ALU zero flag
//   resp_valid   out                response valid
//   resp_ready   in                 response consumer ready
//   resp_result  out  [32]          registered ALU result
//   resp_zero    out                registered zero flag
//   resp_id      out  [IDW]         requester that issued the op
//
// Configuration:
//   ALU_ARB_LOCK_EN  when defined, a handshake with req_lock=1 pins the grant
//                    to that requester until it issues an op with req_lock=0.
//                    When undefined, req_lock is ignored (pure round-robin).
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter  int NREQ           = 2,
  parameter  int ALU_CTRL_WIDTH = 4,
  localparam int IDW            = $clog2(NREQ)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*32-1:0]             req_a,
  input  logic [NREQ*32-1:0]             req_b,
  input  logic [NREQ*ALU_CTRL_WIDTH-1:0] req_ctrl,
  input  logic [NREQ-1:0]                req_lock,
  output logic [31:0]                    alu_a,
  output logic [31:0]                    alu_b,
  output logic [ALU_CTRL_WIDTH-1:0]      alu_ctrl,
  input  logic [31:0]                    alu_result,
  input  logic                           alu_zero,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_result,
  output logic                           resp_zero,
  output logic [IDW-1:0]                 resp_id
);

  // Issue stage
  logic                      r_sValid;
  logic [31:0]               r_sA;
  logic [31:0]               r_sB;
  logic [ALU_CTRL_WIDTH-1:0] r_sCtrl;
  logic [IDW-1:0]            r_sId;

  // Response stage
  logic                      r_respValid;
  logic [31:0]               r_respResult;
  logic                      r_respZero;
  logic [IDW-1:0]            r_respId;

  // Arbitration state
  logic [IDW-1:0]            r_last;

  logic                      w_rFree;
  logic                      w_sAdv;
  logic                      w_sFree;
  logic [NREQ-1:0]           w_eligible;
  logic [NREQ-1:0]           w_grant;
  logic [IDW-1:0]            w_grantId;
  logic                      w_found;
  logic                      w_hs;
  logic [31:0]               w_selA;
  logic [31:0]               w_selB;
  logic [ALU_CTRL_WIDTH-1:0] w_selCtrl;

`ifdef ALU_ARB_LOCK_EN
  logic                      r_lockQ;
  logic [IDW-1:0]            r_lockId;
  logic [NREQ-1:0]           w_lockMask;
  logic                      w_selLock;
`else
  logic                      w_unusedLock;
  assign w_unusedLock = ^req_lock;
`endif

  // Pipeline advance: R can take new data when empty or draining this cycle,
  // and S frees up either when empty or when it moves into R.
  assign w_rFree = !r_respValid || resp_ready;
  assign w_sAdv  = r_sValid && w_rFree;
  assign w_sFree = !r_sValid || w_sAdv;

  // While locked, only the lock owner is eligible for a grant.
`ifdef ALU_ARB_LOCK_EN
  always_comb begin
    w_lockMask           = '0;
    w_lockMask[r_lockId] = 1'b1;
    w_eligible           = r_lockQ ? (req_valid & w_lockMask) : req_valid;
  end
`else
  assign w_eligible = req_valid;
`endif

  // Circular priority scan starting one past the last granted requester.
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    w_grant   = '0;
    w_grantId = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(r_last) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = sum[IDW-1:0];
      if (!w_found && w_eligible[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_grantId    = idx;
      end
    end
  end

  assign req_ready = w_sFree ? w_grant : '0;
  assign w_hs      = w_sFree && w_found;

  // The grant is one-hot, so an OR-style mux over the requester lanes works.
  always_comb begin
    w_selA    = '0;
    w_selB    = '0;
    w_selCtrl = '0;
`ifdef ALU_ARB_LOCK_EN
    w_selLock = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_selA    = req_a[32*i +: 32];
        w_selB    = req_b[32*i +: 32];
        w_selCtrl = req_ctrl[ALU_CTRL_WIDTH*i +: ALU_CTRL_WIDTH];
`ifdef ALU_ARB_LOCK_EN
        w_selLock = req_lock[i];
`endif
      end
    end
  end

  // Issue register: refilled on a handshake, emptied when it advances alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sValid <= 1'b0;
      r_sA     <= '0;
      r_sB     <= '0;
      r_sCtrl  <= '0;
      r_sId    <= '0;
    end else if (w_hs) begin
      r_sValid <= 1'b1;
      r_sA     <= w_selA;
      r_sB     <= w_selB;
      r_sCtrl  <= w_selCtrl;
      r_sId    <= w_grantId;
    end else if (w_sAdv) begin
      r_sValid <= 1'b0;
    end
  end

  // Round-robin pointer moves only when a request is actually accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= IDW'(NREQ - 1);
    end else if (w_hs) begin
      r_last <= w_grantId;
    end
  end

  // Response register captures the ALU output of the op leaving S.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_respValid  <= 1'b0;
      r_respResult <= '0;
      r_respZero   <= 1'b0;
      r_respId     <= '0;
    end else if (w_sAdv) begin
      r_respValid  <= 1'b1;
      r_respResult <= alu_result;
      r_respZero   <= alu_zero;
      r_respId     <= r_sId;
    end else if (r_respValid && resp_ready) begin
      r_respValid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Every handshake while locked comes from the owner, so each handshake
  // simply records whether its op asked to keep the grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lockQ  <= 1'b0;
      r_lockId <= '0;
    end else if (w_hs) begin
      r_lockQ  <= w_selLock;
      r_lockId <= w_grantId;
    end
  end
`endif

  assign alu_a       = r_sA;
  assign alu_b       = r_sB;
  assign alu_ctrl    = r_sCtrl;
  assign resp_valid  = r_respValid;
  assign resp_result = r_respResult;
  assign resp_zero   = r_respZero;
  assign resp_id     = r_respId;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter with three requesters. Each
// requester owns a queue of pending ops; the bench presents the head op
// until it is accepted. Expected responses are queued in the order the
// arbiter should produce them and compared as the DUT emits responses.
// A small combinational ALU model stands in for the external ALU.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int NREQ = 3;
  localparam int CW   = 4;
  localparam int IDW  = 2;

  localparam logic [CW-1:0] OP_ADD  = 4'd0;
  localparam logic [CW-1:0] OP_SUB  = 4'd1;
  localparam logic [CW-1:0] OP_SLT  = 4'd2;
  localparam logic [CW-1:0] OP_SLTU = 4'd3;

  typedef struct packed {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [CW-1:0] ctrl;
    logic          lock;
  } opT;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    result;
    logic           zero;
  } expT;

  logic                 clk;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ*CW-1:0]   req_ctrl;
  logic [NREQ-1:0]      req_lock;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [CW-1:0]        alu_ctrl;
  logic [31:0]          alu_result;
  logic                 alu_zero;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_result;
  logic                 resp_zero;
  logic [IDW-1:0]       resp_id;

  opT  reqQ[NREQ][$];
  expT expQ[$];

  int checkCount;
  int errorCount;
  int hsCount;
  int respCount;

  alu_share_arbiter #(
    .NREQ(NREQ),
    .ALU_CTRL_WIDTH(CW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_ctrl(req_ctrl),
    .req_lock(req_lock),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .resp_zero(resp_zero),
    .resp_id(resp_id)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU
  always_comb begin
    case (alu_ctrl)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic pushOp(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [CW-1:0] ctrl, input logic lock);
    opT op;
    op.a    = a;
    op.b    = b;
    op.ctrl = ctrl;
    op.lock = lock;
    reqQ[r].push_back(op);
  endtask

  task automatic pushExp(input logic [IDW-1:0] id, input logic [31:0] result,
                         input logic zero);
    expT e;
    e.id     = id;
    e.result = result;
    e.zero   = zero;
    expQ.push_back(e);
  endtask

  // Present the head op of every non-empty requester queue
  task automatic driveInputs();
    for (int i = 0; i < NREQ; i++) begin
      if (reqQ[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_a[32*i +: 32]      = reqQ[i][0].a;
        req_b[32*i +: 32]      = reqQ[i][0].b;
        req_ctrl[CW*i +: CW]   = reqQ[i][0].ctrl;
        req_lock[i]            = reqQ[i][0].lock;
      end else begin
        req_valid[i]           = 1'b0;
        req_a[32*i +: 32]      = 32'h0;
        req_b[32*i +: 32]      = 32'h0;
        req_ctrl[CW*i +: CW]   = '0;
        req_lock[i]            = 1'b0;
      end
    end
  endtask

  task automatic clearQueues();
    for (int i = 0; i < NREQ; i++) reqQ[i].delete();
    expQ.delete();
  endtask

  // Run n cycles: drive at negedge, sample handshakes and responses just
  // after, retire accepted ops after the rising edge.
  task automatic applyStimulus(input int n, input logic rrdy);
    logic [NREQ-1:0] hsMask;
    expT             e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      resp_ready = rrdy;
      driveInputs();
      #1;
      hsMask = req_ready;
      if (resp_valid && resp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_result", resp_result, e.result);
          checkOutput("resp_zero", {31'b0, resp_zero}, {31'b0, e.zero});
          checkOutput("resp_id", {30'b0, resp_id}, {30'b0, e.id});
          respCount++;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hsMask[i]) begin
          if (reqQ[i].size() > 0) void'(reqQ[i].pop_front());
          hsCount++;
        end
      end
      driveInputs();
    end
  endtask

  task automatic applyReset();
    resetn     = 1'b0;
    resp_ready = 1'b0;
    clearQueues();
    driveInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    hsCount    = 0;
    respCount  = 0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_ctrl   = '0;
    req_lock   = '0;
    resp_ready = 1'b0;
    resetn     = 1'b0;

    // Reset and idle
    applyReset();
    #1;
    checkOutput("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("idle_req_ready", {29'b0, req_ready}, 32'd0);
    checkOutput("idle_alu_a", alu_a, 32'd0);

    // Single ADD with explicit latency checks
    pushOp(0, 32'd5, 32'd7, OP_ADD, 1'b0);
    pushExp(2'd0, 32'd12, 1'b0);
    @(negedge clk);
    resp_ready = 1'b1;
    driveInputs();
    #1;
    checkOutput("first_grant", {29'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    void'(reqQ[0].pop_front());
    driveInputs();
    @(negedge clk);
    checkOutput("lat_not_yet", {31'b0, resp_valid}, 32'd0);
    checkOutput("issue_alu_a", alu_a, 32'd5);
    checkOutput("issue_alu_b", alu_b, 32'd7);
    applyStimulus(1, 1'b1);
    checkOutput("lat_resp_at_2", 32'(expQ.size()), 32'd0);

    // SUB producing zero
    pushOp(0, 32'd9, 32'd9, OP_SUB, 1'b0);
    pushExp(2'd0, 32'd0, 1'b1);
    applyStimulus(4, 1'b1);
    checkOutput("sub_done", 32'(expQ.size()), 32'd0);

    // Round-robin with all three continuously valid
    applyReset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        pushOp(i, 32'(100 * i + j), 32'd10, OP_ADD, 1'b0);
      end
    end
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        pushExp(IDW'(i), 32'(100 * i + j + 10), 1'b0);
      end
    end
    respCount = 0;
    applyStimulus(8, 1'b1);
    checkOutput("rr_throughput", 32'(respCount), 32'd6);
    checkOutput("rr_done", 32'(expQ.size()), 32'd0);

    // Backpressure: two accepts, then stall with the first result held
    applyReset();
    pushOp(0, 32'd1, 32'd2, OP_ADD, 1'b0);
    pushOp(0, 32'd3, 32'd4, OP_ADD, 1'b0);
    pushOp(0, 32'd10, 32'd20, OP_ADD, 1'b0);
    pushExp(2'd0, 32'd3, 1'b0);
    pushExp(2'd0, 32'd7, 1'b0);
    pushExp(2'd0, 32'd30, 1'b0);
    hsCount = 0;
    applyStimulus(4, 1'b0);
    checkOutput("bp_hs_count", 32'(hsCount), 32'd2);
    checkOutput("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("bp_resp_hold", resp_result, 32'd3);
    checkOutput("bp_alu_hold", alu_a, 32'd3);
    applyStimulus(1, 1'b1);
    checkOutput("bp_second_next", 32'(expQ.size()), 32'd2);
    applyStimulus(1, 1'b1);
    checkOutput("bp_second_done", 32'(expQ.size()), 32'd1);
    applyStimulus(3, 1'b1);
    checkOutput("bp_all_done", 32'(expQ.size()), 32'd0);

    // Signed and unsigned compare on requester 1
    applyReset();
    pushOp(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 1'b0);
    pushOp(1, 32'hFFFF_FFFF, 32'd1, OP_SLTU, 1'b0);
    pushExp(2'd1, 32'd1, 1'b0);
    pushExp(2'd1, 32'd0, 1'b1);
    applyStimulus(5, 1'b1);
    checkOutput("cmp_done", 32'(expQ.size()), 32'd0);

    // Reset mid-operation with both stages full
    applyReset();
    pushOp(2, 32'h1234, 32'h1, OP_ADD, 1'b0);
    pushOp(2, 32'h5678, 32'h2, OP_ADD, 1'b0);
    applyStimulus(2, 1'b0);
    checkOutput("pre_rst_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("pre_rst_alu_a", alu_a, 32'h5678);
    clearQueues();
    driveInputs();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_result", resp_result, 32'd0);
    checkOutput("rst_resp_zero", {31'b0, resp_zero}, 32'd0);
    checkOutput("rst_resp_id", {30'b0, resp_id}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(4, 1'b1);
    checkOutput("post_rst_idle", {31'b0, resp_valid}, 32'd0);

    // Lock sequence: req0 holds the grant across a locked pair of ops
    applyReset();
    pushOp(0, 32'd1, 32'd1, OP_ADD, 1'b1);
    pushOp(0, 32'd2, 32'd2, OP_ADD, 1'b1);
    pushOp(0, 32'd3, 32'd3, OP_ADD, 1'b0);
    pushOp(1, 32'd50, 32'd1, OP_ADD, 1'b0);
    pushOp(1, 32'd60, 32'd1, OP_ADD, 1'b0);
`ifdef ALU_ARB_LOCK_EN
    pushExp(2'd0, 32'd2, 1'b0);
    pushExp(2'd0, 32'd4, 1'b0);
    pushExp(2'd0, 32'd6, 1'b0);
    pushExp(2'd1, 32'd51, 1'b0);
    pushExp(2'd1, 32'd61, 1'b0);
`else
    pushExp(2'd0, 32'd2, 1'b0);
    pushExp(2'd1, 32'd51, 1'b0);
    pushExp(2'd0, 32'd4, 1'b0);
    pushExp(2'd1, 32'd61, 1'b0);
    pushExp(2'd0, 32'd6, 1'b0);
`endif
    applyStimulus(10, 1'b1);
    checkOutput("lock_done", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational `alu` instance between `NREQ` requesters (e.g. the main multicycle datapath, the AMO unit and the page-table walker) with round-robin arbitration. It provides a per-requester valid/ready request channel and a single tagged response channel. The block sits between the requesters and the ALU and drives the ALU's operand and control inputs from an internal issue register. A registered response stage gives full throughput of one operation per cycle with backpressure.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..8.
- `IDW`, derived as `$clog2(NREQ)`: width of the requester ID.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: request valid, one bit per requester.
- `req_ready` output NREQ: request accepted this cycle, one-hot or zero.
- `req_a` input NREQ*32: operand A, packed, requester i at `[32*i+:32]`.
- `req_b` input NREQ*32: operand B, packed the same way.
- `req_ctrl` input NREQ*`ALU_CTRL_WIDTH`: ALU control code per requester, from `riscv_defines.svh`.
- `req_lock` input NREQ: hold the grant after this op (see Configuration).
- `alu_a` output 32: to ALU operand A.
- `alu_b` output 32: to ALU operand B.
- `alu_ctrl` output `ALU_CTRL_WIDTH`: to ALU control input.
- `alu_result` input 32: from ALU result.
- `alu_zero` input 1: from ALU zero flag.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: response consumer ready.
- `resp_result` output 32: registered ALU result.
- `resp_zero` output 1: registered zero flag.
- `resp_id` output IDW: index of the requester that issued the op.

## Operation
- **Issue stage (S):**
  - Registers `s_valid`, `s_a`, `s_b`, `s_ctrl` and `s_id`.
  - `alu_a`/`alu_b`/`alu_ctrl` are driven directly from `s_a`/`s_b`/`s_ctrl`.
- **Response stage (R):**
  - Registers `resp_valid`, `resp_result`, `resp_zero` and `resp_id`.
- **Stage advance conditions:**
  - `r_free = !resp_valid | resp_ready`.
  - `s_adv = s_valid & r_free`.
  - `s_free = !s_valid | s_adv`.
- **Grant:** combinational.
  - The first requester with `req_valid` set wins, scanning circularly from `last+1`.
  - `req_ready[i] = s_free & grant[i]`.
  - A handshake on requester i loads S with that requester's operands and sets `last <= i`.
  - `last` changes only on a handshake.
- **S to R:** on `s_adv`, R captures `alu_result`, `alu_zero` and `s_id`, and `resp_valid` is set. `s_valid` is cleared unless a new handshake refills S in the same cycle.
- **Response handshake:** when `resp_valid & resp_ready` with no `s_adv`, `resp_valid` is cleared.
- **Requester rules:**
  - `req_valid`, operands and ctrl must hold until ready; they must not depend on `req_ready`.
  - `req_ready` may depend on `req_valid`.
- **Reset (asynchronous, `resetn=0`):**
  - `s_valid=0`, `resp_valid=0`.
  - All data registers are 0, so `alu_a`/`alu_b`/`alu_ctrl`/`resp_result`/`resp_id` are 0 and `resp_zero` is 0.
  - `last=NREQ-1`, so requester 0 has first priority.
  - The lock is cleared.
  - In-flight ops are discarded and no response is produced for them.
- **Boundary cases:**
  - R full and `resp_ready=0`: S holds and its ALU inputs stay stable. If S is also full, all `req_ready` are 0.
  - `resp_ready=1` in the same cycle as `s_valid`: R is replaced by S's result, S accepts a new op, and throughput is 1 op/cycle.
  - No `req_valid`: the grant is zero and `last` is unchanged.

## Timing
- **Latency:** handshake at edge k; the result is visible on `resp_*` after edge k+1 (2 cycles valid-to-response when there is no backpressure).
- **Throughput:** sustained 1 op/cycle with `resp_ready` held at 1.
- **Combinational paths:**
  - `req_valid` to `req_ready` (arbiter).
  - `resp_ready` to `req_ready`.
  - S registers through the external ALU to the R D-inputs, a single ALU delay.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NREQ-1 with no requester starved for more than NREQ-1 handshakes (lock excepted).

## Configuration
- Macro: `ALU_ARB_LOCK_EN`.
- **Defined:**
  - A handshake with `req_lock[i]=1` sets `lock_q=1` and `lock_id=i`.
  - While `lock_q=1`, only requester `lock_id` can be granted; others see `req_ready=0`.
  - A handshake by `lock_id` with `req_lock=0` clears the lock after that op.
  - Used for AMO read-modify-write sequences.
- **Undefined:** `req_lock` is ignored, no lock state is instantiated, and arbitration is pure round-robin.

## Test plan
- **Reset and idle:** reset mid-op with `s_valid=1` and `resp_valid=1` → all outputs 0 immediately, `resp_valid` stays 0 after release with no requests.
- **Single op:** req0 ADD a=5 b=7, `resp_ready=1` → `resp_valid` 2 cycles later with `result=12`, `zero=0`, `id=0`. Req0 SUB 9-9 → `result=0`, `zero=1`.
- **Round-robin:** NREQ=3, all three valid continuously with distinct ADD ops → grant order 0,1,2,0,1,2 and responses in the same order at 1/cycle.
- **Backpressure:** `resp_ready=0` for 4 cycles after two accepted ops → exactly two handshakes, `resp` holds the first result stable. `resp_ready=1` → second result next cycle, then new accepts resume.
- **Compare ops:** req1 SLT a=0xFFFFFFFF b=1 → `result=1`. SLTU with the same operands → `result=0`, `resp_id=1`.
- **Lock (`ALU_ARB_LOCK_EN`):** req0 issues with lock=1 while req1 is valid → the next two grants go to req0, and req1 is granted only after req0 issues with lock=0. Without the macro the same stimulus alternates 0,1.
